// File: rtl/dm_port_sched_pkg.sv
// Shared types and DM encodings for the data-memory port scheduler and its store buffer.
package dm_port_sched_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
    logic        valid;
  } sb_entry_t;

  typedef enum logic [1:0] {DmIdle, DmRead, DmWrite} dm_op_t;

  typedef enum logic [1:0] {StNorm, StConfl, StFence} sched_state_t;

  // DM chip enable and write enables are active-low.
  localparam logic        DmCenActive = 1'b0;
  localparam logic        DmCenIdle   = 1'b1;
  localparam logic [31:0] DmWenNone   = 32'hFFFF_FFFF;

  function automatic logic [31:0] wstrb_to_wen(logic [3:0] wstrb);
    logic [31:0] wen;
    for (int i = 0; i < 4; i++) begin
      wen[8*i +: 8] = {8{~wstrb[i]}};
    end
    return wen;
  endfunction

endpackage

// File: rtl/dm_port_sched_sb.sv
// In-order committed store buffer: circular array with count, head view and a
// per-entry word-address match vector.
module dm_port_sched_sb import dm_port_sched_pkg::*; #(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enq_i,
  input  logic [31:0]                enq_addr_i,
  input  logic [31:0]                enq_data_i,
  input  logic [3:0]                 enq_wstrb_i,
  input  logic                       deq_i,
  input  logic [29:0]                cmp_word_i,
  output logic [31:0]                head_addr_o,
  output logic [31:0]                head_data_o,
  output logic [3:0]                 head_wstrb_o,
  output logic [$clog2(Depth)-1:0]   head_idx_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic [Depth-1:0]           match_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  sb_entry_t           entries_q [Depth];
  logic [IdxW-1:0]     head_q, head_d;
  logic [IdxW-1:0]     tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d;

  // Pointers wrap naturally since Depth is a power of two.
  assign head_d  = head_q + IdxW'(deq_i);
  assign tail_d  = tail_q + IdxW'(enq_i);
  assign count_d = count_q + CntW'(enq_i) - CntW'(deq_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (deq_i) begin
        entries_q[head_q].valid <= 1'b0;
      end
      if (enq_i) begin
        entries_q[tail_q] <= '{addr: enq_addr_i, data: enq_data_i, wstrb: enq_wstrb_i,
                               valid: 1'b1};
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    match_o = '0;
    for (int i = 0; i < Depth; i++) begin
      match_o[i] = entries_q[i].valid && (entries_q[i].addr[31:2] == cmp_word_i);
    end
  end

  assign head_addr_o  = entries_q[head_q].addr;
  assign head_data_o  = entries_q[head_q].data;
  assign head_wstrb_o = entries_q[head_q].wstrb;
  assign head_idx_o   = head_q;
  assign count_o      = count_q;

endmodule

// File: rtl/dm_port_sched.sv
// Single-port DM scheduler: arbitrates loads against committed-store drains with
// starvation, address-conflict and fence handling, and drives every DM control.
module dm_port_sched import dm_port_sched_pkg::*; #(
  parameter int unsigned SbDepth     = 4,
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_req_valid_i,
  input  logic [31:0] ld_req_addr_i,
  output logic        ld_req_ready_o,
  input  logic        ld_kill_i,
  output logic        ld_rsp_valid_o,
  output logic [31:0] ld_rsp_data_o,
  input  logic        st_req_valid_i,
  input  logic [31:0] st_req_addr_i,
  input  logic [31:0] st_req_data_i,
  input  logic [3:0]  st_req_wstrb_i,
  output logic        st_req_ready_o,
  input  logic        fence_req_i,
  output logic        fence_done_o,
  output logic        sb_empty_o,
  input  logic [31:0] dm_rd_data_i,
  output logic        dm_c_en_o,
  output logic        dm_r_en_o,
  output logic [31:0] dm_w_en_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_w_data_o
);

  localparam int unsigned IdxW = $clog2(SbDepth);
  localparam int unsigned CntW = $clog2(SbDepth) + 1;
  localparam int unsigned StW  = $clog2(StarveLimit + 1);

  sched_state_t       state_q, state_d;
  logic [29:0]        confl_word_q, confl_word_d;
  logic [StW-1:0]     starve_q, starve_d;
  logic               rd_grant_q;
  dm_op_t             op;

  logic [31:0]        head_addr, head_data;
  logic [3:0]         head_wstrb;
  logic [IdxW-1:0]    head_idx;
  logic [CntW-1:0]    count;
  logic [SbDepth-1:0] match, head_mask;
  logic [29:0]        cmp_word;
  logic               sb_nonempty, starved, enq, deq, enq_match, conflict, remaining;

  assign sb_nonempty    = (count != '0);
  assign st_req_ready_o = (count != CntW'(SbDepth));
  assign sb_empty_o     = !sb_nonempty;
  assign starved        = (starve_q == StW'(StarveLimit));
  assign enq            = st_req_valid_i && st_req_ready_o && !rst_i;
  assign deq            = (op == DmWrite);

  // While stalled on a conflict, ordering is tracked against the held load word.
  assign cmp_word  = (state_q == StConfl) ? confl_word_q : ld_req_addr_i[31:2];
  assign enq_match = enq && (st_req_addr_i[31:2] == cmp_word);
  assign conflict  = ld_req_valid_i && ((|match) || enq_match);
  assign head_mask = deq ? (SbDepth'(1) << head_idx) : '0;
  // A matching store still pending once this cycle's drain and enqueue settle.
  assign remaining = (|(match & ~head_mask)) || enq_match;

  dm_port_sched_sb #(
    .Depth (SbDepth)
  ) u_sb (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enq_i        (enq),
    .enq_addr_i   (st_req_addr_i),
    .enq_data_i   (st_req_data_i),
    .enq_wstrb_i  (st_req_wstrb_i),
    .deq_i        (deq),
    .cmp_word_i   (cmp_word),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .head_wstrb_o (head_wstrb),
    .head_idx_o   (head_idx),
    .count_o      (count),
    .match_o      (match)
  );

  always_comb begin
    op = DmIdle;
    if (!rst_i) begin
      if (state_q == StNorm && ld_req_valid_i && !conflict && !starved) begin
        op = DmRead;
      end else if (sb_nonempty) begin
        op = DmWrite;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    confl_word_d = confl_word_q;
    unique case (state_q)
      StNorm: begin
        if (fence_req_i) begin
          state_d = StFence;
        end else if (conflict && remaining) begin
          state_d      = StConfl;
          confl_word_d = ld_req_addr_i[31:2];
        end
      end
      StConfl: begin
        if (fence_req_i) begin
          state_d = StFence;
        end else if (!remaining) begin
          state_d = StNorm;
        end
      end
      StFence: begin
        if (!fence_req_i) begin
          state_d = StNorm;
        end
      end
      default: state_d = StNorm;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (deq || !sb_nonempty) begin
      starve_d = '0;
    end else if (op == DmRead && !starved) begin
      starve_d = starve_q + StW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StNorm;
      confl_word_q <= '0;
      starve_q     <= '0;
      rd_grant_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      confl_word_q <= confl_word_d;
      starve_q     <= starve_d;
      rd_grant_q   <= (op == DmRead);
    end
  end

  assign ld_req_ready_o = (op == DmRead);
  assign ld_rsp_valid_o = rd_grant_q && !ld_kill_i;
  assign ld_rsp_data_o  = dm_rd_data_i;
  assign fence_done_o   = (state_q == StFence) && !sb_nonempty;

  always_comb begin
    dm_c_en_o   = DmCenIdle;
    dm_r_en_o   = 1'b0;
    dm_w_en_o   = DmWenNone;
    dm_addr_o   = '0;
    dm_w_data_o = '0;
    unique case (op)
      DmRead: begin
        dm_c_en_o = DmCenActive;
        dm_r_en_o = 1'b1;
        dm_addr_o = ld_req_addr_i;
      end
      DmWrite: begin
        dm_c_en_o   = DmCenActive;
        dm_w_en_o   = wstrb_to_wen(head_wstrb);
        dm_addr_o   = head_addr;
        dm_w_data_o = head_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_port_sched.sv
// Bench for dm_port_sched: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based scheduler model.
module tb_dm_port_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_req_valid, ld_req_ready, ld_kill, ld_rsp_valid;
  logic [31:0] ld_req_addr, ld_rsp_data;
  logic        st_req_valid, st_req_ready;
  logic [31:0] st_req_addr, st_req_data;
  logic [3:0]  st_req_wstrb;
  logic        fence_req, fence_done, sb_empty;
  logic [31:0] dm_rd_data, dm_w_en, dm_addr, dm_w_data;
  logic        dm_c_en, dm_r_en;

  always #5 clk = ~clk;

  dm_port_sched dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ld_req_valid_i (ld_req_valid),
    .ld_req_addr_i  (ld_req_addr),
    .ld_req_ready_o (ld_req_ready),
    .ld_kill_i      (ld_kill),
    .ld_rsp_valid_o (ld_rsp_valid),
    .ld_rsp_data_o  (ld_rsp_data),
    .st_req_valid_i (st_req_valid),
    .st_req_addr_i  (st_req_addr),
    .st_req_data_i  (st_req_data),
    .st_req_wstrb_i (st_req_wstrb),
    .st_req_ready_o (st_req_ready),
    .fence_req_i    (fence_req),
    .fence_done_o   (fence_done),
    .sb_empty_o     (sb_empty),
    .dm_rd_data_i   (dm_rd_data),
    .dm_c_en_o      (dm_c_en),
    .dm_r_en_o      (dm_r_en),
    .dm_w_en_o      (dm_w_en),
    .dm_addr_o      (dm_addr),
    .dm_w_data_o    (dm_w_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expand_wen(input logic [3:0] s);
    logic [31:0] w;
    w = 32'hFFFF_FFFF;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = 8'h00;
    return w;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
  } st_t;

  st_t         sbq[$];
  int          mode;      // 0 normal, 1 held on conflict, 2 fencing
  logic [29:0] held;
  int          starve;
  bit          prev_read;
  bit          started;

  int          m_op;      // 0 idle, 1 read, 2 write
  bit          m_enq, m_confl, m_rem;
  logic [29:0] m_cmp;
  logic [31:0] e_wen, e_addr, e_data;
  st_t         m_new;

  always @(negedge clk) begin
    m_enq = st_req_valid && (sbq.size() < 4) && !rst;
    m_confl = 1'b0;
    if (ld_req_valid) begin
      foreach (sbq[i]) if (sbq[i].addr[31:2] == ld_req_addr[31:2]) m_confl = 1'b1;
      if (m_enq && st_req_addr[31:2] == ld_req_addr[31:2]) m_confl = 1'b1;
    end
    if (rst) m_op = 0;
    else if (mode == 0 && ld_req_valid && !m_confl && starve < 4) m_op = 1;
    else if (sbq.size() > 0) m_op = 2;
    else m_op = 0;

    m_cmp = (mode == 1) ? held : ld_req_addr[31:2];
    m_rem = m_enq && (st_req_addr[31:2] == m_cmp);
    for (int i = (m_op == 2) ? 1 : 0; i < sbq.size(); i++)
      if (sbq[i].addr[31:2] == m_cmp) m_rem = 1'b1;

    e_wen  = (m_op == 2) ? expand_wen(sbq[0].wstrb) : 32'hFFFF_FFFF;
    e_addr = (m_op == 1) ? ld_req_addr : (m_op == 2) ? sbq[0].addr : 32'h0;
    e_data = (m_op == 2) ? sbq[0].data : 32'h0;

    if (started) begin
      chk("ld_req_ready", {31'b0, ld_req_ready}, {31'b0, m_op == 1});
      chk("dm_c_en", {31'b0, dm_c_en}, {31'b0, m_op == 0});
      chk("dm_r_en", {31'b0, dm_r_en}, {31'b0, m_op == 1});
      chk("dm_w_en", dm_w_en, e_wen);
      chk("dm_addr", dm_addr, e_addr);
      chk("dm_w_data", dm_w_data, e_data);
      chk("ld_rsp_valid", {31'b0, ld_rsp_valid}, {31'b0, prev_read && !ld_kill});
      if (prev_read && !ld_kill) chk("ld_rsp_data", ld_rsp_data, dm_rd_data);
      chk("st_req_ready", {31'b0, st_req_ready}, {31'b0, sbq.size() < 4});
      chk("sb_empty", {31'b0, sb_empty}, {31'b0, sbq.size() == 0});
      chk("fence_done", {31'b0, fence_done}, {31'b0, mode == 2 && sbq.size() == 0});
    end

    if (rst) begin
      sbq.delete();
      mode = 0;
      starve = 0;
      prev_read = 1'b0;
      started = 1'b1;
    end else begin
      case (mode)
        0: if (fence_req) mode = 2;
           else if (m_confl && m_rem) begin mode = 1; held = ld_req_addr[31:2]; end
        1: if (fence_req) mode = 2; else if (!m_rem) mode = 0;
        default: if (!fence_req) mode = 0;
      endcase
      if (m_op == 2 || sbq.size() == 0) starve = 0;
      else if (m_op == 1 && starve < 4) starve++;
      prev_read = (m_op == 1);
      if (m_op == 2) void'(sbq.pop_front());
      if (m_enq) begin
        m_new.addr = st_req_addr;
        m_new.data = st_req_data;
        m_new.wstrb = st_req_wstrb;
        sbq.push_back(m_new);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_in();
    ld_req_valid = 1'b0; ld_req_addr = '0; ld_kill = 1'b0;
    st_req_valid = 1'b0; st_req_addr = '0; st_req_data = '0; st_req_wstrb = '0;
    fence_req = 1'b0; dm_rd_data = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    repeat (3) nxt();
    rst = 1'b0;

    // Reset state
    smp();
    chk("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
    chk("rst_st_ready", {31'b0, st_req_ready}, 32'd1);
    chk("rst_ld_ready", {31'b0, ld_req_ready}, 32'd0);
    chk("rst_c_en", {31'b0, dm_c_en}, 32'd1);
    chk("rst_w_en", dm_w_en, 32'hFFFF_FFFF);
    chk("rst_fence_done", {31'b0, fence_done}, 32'd0);

    // Basic load
    nxt(); ld_req_valid = 1'b1; ld_req_addr = 32'h100;
    smp();
    chk("load_ready", {31'b0, ld_req_ready}, 32'd1);
    chk("load_r_en", {31'b0, dm_r_en}, 32'd1);
    chk("load_addr", dm_addr, 32'h100);
    nxt(); idle_in(); dm_rd_data = 32'hDEAD_BEEF;
    smp();
    chk("load_rsp_valid", {31'b0, ld_rsp_valid}, 32'd1);
    chk("load_rsp_data", ld_rsp_data, 32'hDEAD_BEEF);

    // Byte store drain
    nxt(); idle_in();
    st_req_valid = 1'b1; st_req_addr = 32'h204; st_req_data = 32'h1122_3344; st_req_wstrb = 4'b0001;
    smp();
    nxt(); idle_in();
    smp();
    chk("bst_w_en", dm_w_en, 32'hFFFF_FF00);
    chk("bst_addr", dm_addr, 32'h204);
    chk("bst_data", dm_w_data, 32'h1122_3344);
    chk("bst_c_en", {31'b0, dm_c_en}, 32'd0);
    nxt();
    smp();
    chk("bst_sb_empty", {31'b0, sb_empty}, 32'd1);

    // Starvation: two stores behind a continuous load stream
    for (int i = 0; i < 12; i++) begin
      nxt(); idle_in();
      ld_req_valid = 1'b1; ld_req_addr = 32'h100;
      st_req_valid = (i < 2); st_req_addr = 32'h400 + 32'(4 * i);
      st_req_data = 32'(i); st_req_wstrb = 4'hF;
      smp();
      chk("starve_ready", {31'b0, ld_req_ready}, {31'b0, !(i == 5 || i == 10)});
      if (i == 5) chk("starve_waddr0", dm_addr, 32'h400);
      if (i == 10) chk("starve_waddr1", dm_addr, 32'h404);
    end

    // Address conflict
    nxt(); idle_in();
    ld_req_valid = 1'b1; ld_req_addr = 32'h100;
    st_req_valid = 1'b1; st_req_addr = 32'h300; st_req_data = 32'hA5A5_0300; st_req_wstrb = 4'hF;
    smp();
    nxt(); idle_in(); ld_req_valid = 1'b1; ld_req_addr = 32'h302;
    smp();
    chk("confl_ready", {31'b0, ld_req_ready}, 32'd0);
    chk("confl_waddr", dm_addr, 32'h300);
    chk("confl_r_en", {31'b0, dm_r_en}, 32'd0);
    nxt();
    smp();
    chk("confl_accept", {31'b0, ld_req_ready}, 32'd1);
    chk("confl_raddr", dm_addr, 32'h302);

    // Full SB, then fence
    for (int i = 0; i < 10; i++) begin
      nxt(); idle_in();
      ld_req_valid = 1'b1; ld_req_addr = 32'h100;
      st_req_valid = (i < 4); st_req_addr = 32'h500 + 32'(4 * i);
      st_req_data = 32'hF000_0000 + 32'(i); st_req_wstrb = 4'hF;
      fence_req = (i >= 5);
      smp();
      if (i == 4) chk("full_st_ready", {31'b0, st_req_ready}, 32'd0);
      if (i >= 5 && i <= 8) begin
        chk("fence_ready", {31'b0, ld_req_ready}, 32'd0);
        chk("fence_waddr", dm_addr, 32'h500 + 32'(4 * (i - 5)));
      end
      if (i == 9) begin
        chk("fence_done", {31'b0, fence_done}, 32'd1);
        chk("fence_blocked", {31'b0, ld_req_ready}, 32'd0);
        chk("fence_idle", {31'b0, dm_c_en}, 32'd1);
      end
    end
    nxt(); idle_in();
    smp();
    nxt();
    smp();
    chk("fence_exit", {31'b0, fence_done}, 32'd0);

    // Kill
    nxt(); ld_req_valid = 1'b1; ld_req_addr = 32'h100;
    smp();
    nxt(); idle_in(); ld_kill = 1'b1; dm_rd_data = 32'hCAFE_F00D;
    smp();
    chk("kill_rsp_valid", {31'b0, ld_rsp_valid}, 32'd0);

    // Reset with three stores pending
    for (int i = 0; i < 4; i++) begin
      nxt(); idle_in();
      ld_req_valid = 1'b1; ld_req_addr = 32'h100;
      st_req_valid = (i < 3); st_req_addr = 32'h600 + 32'(4 * i);
      st_req_data = 32'(i); st_req_wstrb = 4'hF;
      smp();
    end
    chk("pre_rst_sb_empty", {31'b0, sb_empty}, 32'd0);
    nxt(); idle_in(); rst = 1'b1;
    smp();
    chk("in_rst_c_en", {31'b0, dm_c_en}, 32'd1);
    nxt(); rst = 1'b0;
    smp();
    chk("post_rst_sb_empty", {31'b0, sb_empty}, 32'd1);
    chk("post_rst_c_en", {31'b0, dm_c_en}, 32'd1);

    // Randomized traffic over a small address pool so conflicts are frequent
    for (int c = 0; c < 3000; c++) begin
      nxt();
      ld_req_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0)
        ld_req_addr = 32'h700 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      st_req_valid = ($urandom_range(0, 2) == 0);
      st_req_addr = 32'h700 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      st_req_data = $urandom;
      st_req_wstrb = 4'($urandom_range(1, 15));
      ld_kill = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) fence_req = !fence_req;
      rst = ($urandom_range(0, 499) == 0);
      dm_rd_data = $urandom;
    end

    nxt(); idle_in(); rst = 1'b0;
    repeat (8) nxt();
    smp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
